xvc_jtag_shifter: RTL and testbench

AXI4-Lite slave that implements the Xilinx Virtual Cable shift engine for the XEM8320 PCIe XVC design. It sits directly downstream of the PCIe-to-AXI bridge in `pciebd`, on one BAR-mapped AXI-Lite window. Host software writes a bit count, a TMS vector and a TDI vector, then sets a start bit. The block clocks the vectors out on TCK/TMS/TDI and returns the TDO bits captured on each rising TCK edge.

---
 rtl/xvc_pkg.sv | 32 +++
 rtl/xvc_jtag_shifter_if.sv | 36 +++
 rtl/xvc_tck_div.sv | 39 +++
 rtl/xvc_jtag_shifter.sv | 219 +++++++++++++++++++++
 tb/tb_xvc_jtag_shifter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/xvc_pkg.sv
// Shared definitions for the XVC JTAG shift engine: register offsets,
// control bit index, shift FSM states and length clamp helper.
package xvc_pkg;

    localparam int unsigned OFF_LEN  = 32'h0000_0000;
    localparam int unsigned OFF_TMS  = 32'h0000_0004;
    localparam int unsigned OFF_TDI  = 32'h0000_0008;
    localparam int unsigned OFF_TDO  = 32'h0000_000C;
    localparam int unsigned OFF_CTRL = 32'h0000_0010;

    localparam int unsigned CTRL_START_BIT = 32'd0;
    localparam int unsigned MAX_LEN        = 32'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } xvc_state_e;

    // Lengths beyond the vector width shift the full vector.
    function automatic logic [5:0] clamp_len(input logic [5:0] raw);
        logic [5:0] res;
        if (raw > 6'(MAX_LEN)) begin
            res = 6'(MAX_LEN);
        end else begin
            res = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/xvc_jtag_shifter_if.sv
// AXI4-Lite slave bundle for the XVC shift engine register window.
interface xvc_jtag_shifter_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] s_axil_awaddr;
    logic              s_axil_awvalid;
    logic              s_axil_awready;
    logic [31:0]       s_axil_wdata;
    logic [3:0]        s_axil_wstrb;
    logic              s_axil_wvalid;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready;
    logic [ADDR_W-1:0] s_axil_araddr;
    logic              s_axil_arvalid;
    logic              s_axil_arready;
    logic [31:0]       s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready;

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );
endinterface

// File: rtl/xvc_tck_div.sv
// TCK half-period timer: one-cycle tick every TCK_DIV enabled cycles,
// count held at zero while disabled so each enable rise starts fresh.
module xvc_tck_div #(
    parameter int TCK_DIV = 5
) (
    input  logic clk100,
    input  logic resetn,
    input  logic en,
    output logic tick
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en & (cnt_q == LAST);

    // Next count: clear when idle or at wrap, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk100 or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xvc_jtag_shifter.sv
// XVC shift engine: AXI-Lite register window plus TCK/TMS/TDI/TDO shift FSM.
// Define XVC_LOOPBACK_EN to sample TDO from the internal TDI bit for self-test.
module xvc_jtag_shifter
    import xvc_pkg::*;
#(
    parameter int TCK_DIV = 5,
    parameter int ADDR_W  = 5
) (
    input  logic                clk100,
    input  logic                resetn,
    xvc_jtag_shifter_if.slave   axil,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    input  logic                jtag_tdo,
    output logic                busy
);

    xvc_state_e  state_q, state_d;
    logic [5:0]  len_q, len_d, len_w_q, len_w_d, idx_q, idx_d;
    logic [31:0] tms_q, tms_d, tdi_q, tdi_d, tdo_q, tdo_d;
    logic [31:0] tms_w_q, tms_w_d, tdi_w_q, tdi_w_d, tdo_w_q, tdo_w_d;
    logic        tck_q, tck_d, busy_q, busy_d;
    logic        awready_q, awready_d, bvalid_q, bvalid_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic [ADDR_W-1:0] waddr_s, raddr_s;
    logic        wr_fire_s, wr_ok_s, rd_fire_s, start_s, tick_s, div_en_s, sample_s;

    assign waddr_s   = axil.s_axil_awaddr;
    assign raddr_s   = axil.s_axil_araddr;
    assign wr_fire_s = awready_q & axil.s_axil_awvalid & axil.s_axil_wvalid;
    assign wr_ok_s   = wr_fire_s & (axil.s_axil_wstrb == 4'hF) & ~busy_q;
    assign rd_fire_s = arready_q & axil.s_axil_arvalid;
    assign start_s   = wr_ok_s & (32'(waddr_s) == OFF_CTRL)
                       & axil.s_axil_wdata[CTRL_START_BIT];
    assign div_en_s  = (state_q == LOW) || (state_q == HIGH);

`ifdef XVC_LOOPBACK_EN
    assign sample_s = tdi_w_q[0];
`else
    assign sample_s = jtag_tdo;
`endif

    xvc_tck_div #(.TCK_DIV(TCK_DIV)) u_tck_div (
        .clk100 (clk100),
        .resetn (resetn),
        .en     (div_en_s),
        .tick   (tick_s)
    );

    assign axil.s_axil_awready = awready_q;
    assign axil.s_axil_wready  = awready_q;
    assign axil.s_axil_bresp   = 2'b00;
    assign axil.s_axil_bvalid  = bvalid_q;
    assign axil.s_axil_arready = arready_q;
    assign axil.s_axil_rdata   = rdata_q;
    assign axil.s_axil_rresp   = 2'b00;
    assign axil.s_axil_rvalid  = rvalid_q;

    assign jtag_tck = tck_q;
    assign jtag_tms = tms_w_q[0];
    assign jtag_tdi = tdi_w_q[0];
    assign busy     = busy_q;

    // AXI-Lite channel handshakes, register writes and read mux.
    always_comb begin
        awready_d = axil.s_axil_awvalid & axil.s_axil_wvalid & ~bvalid_q & ~awready_q;
        arready_d = axil.s_axil_arvalid & ~rvalid_q & ~arready_q;
        len_d     = len_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        rdata_d   = rdata_q;

        if (wr_fire_s) begin
            bvalid_d = 1'b1;
        end else if (axil.s_axil_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        if (rd_fire_s) begin
            rvalid_d = 1'b1;
        end else if (axil.s_axil_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end

        if (wr_ok_s) begin
            case (32'(waddr_s))
                OFF_LEN: len_d = axil.s_axil_wdata[5:0];
                OFF_TMS: tms_d = axil.s_axil_wdata;
                OFF_TDI: tdi_d = axil.s_axil_wdata;
                default: len_d = len_q;
            endcase
        end else begin
            len_d = len_q;
        end

        if (rd_fire_s) begin
            case (32'(raddr_s))
                OFF_LEN:  rdata_d = {26'd0, len_q};
                OFF_TMS:  rdata_d = tms_q;
                OFF_TDI:  rdata_d = tdi_q;
                OFF_TDO:  rdata_d = tdo_q;
                OFF_CTRL: rdata_d = {31'd0, busy_q};
                default:  rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Shift FSM: vectors shift right so bit 0 of each working copy drives the pin.
    always_comb begin
        state_d = state_q;
        len_w_d = len_w_q;
        idx_d   = idx_q;
        tms_w_d = tms_w_q;
        tdi_w_d = tdi_w_q;
        tdo_w_d = tdo_w_q;
        tdo_d   = tdo_q;
        tck_d   = tck_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    len_w_d = clamp_len(len_q);
                    idx_d   = 6'd0;
                    tms_w_d = tms_q;
                    tdi_w_d = tdi_q;
                    tdo_w_d = 32'd0;
                    busy_d  = 1'b1;
                    state_d = (clamp_len(len_q) == 6'd0) ? DONE : LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (tick_s) begin
                    tck_d                = 1'b1;
                    tdo_w_d[idx_q[4:0]]  = sample_s;
                    state_d              = HIGH;
                end else begin
                    state_d = LOW;
                end
            end
            HIGH: begin
                if (tick_s) begin
                    tck_d = 1'b0;
                    if ((idx_q + 6'd1) == len_w_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        tms_w_d = tms_w_q >> 1;
                        tdi_w_d = tdi_w_q >> 1;
                        state_d = LOW;
                    end
                end else begin
                    state_d = HIGH;
                end
            end
            DONE: begin
                tdo_d   = tdo_w_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register update; reset drops TCK and discards any shift.
    always_ff @(posedge clk100 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            len_q     <= 6'd0;
            tms_q     <= 32'd0;
            tdi_q     <= 32'd0;
            tdo_q     <= 32'd0;
            len_w_q   <= 6'd0;
            idx_q     <= 6'd0;
            tms_w_q   <= 32'd0;
            tdi_w_q   <= 32'd0;
            tdo_w_q   <= 32'd0;
            tck_q     <= 1'b0;
            busy_q    <= 1'b0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            tdo_q     <= tdo_d;
            len_w_q   <= len_w_d;
            idx_q     <= idx_d;
            tms_w_q   <= tms_w_d;
            tdi_w_q   <= tdi_w_d;
            tdo_w_q   <= tdo_w_d;
            tck_q     <= tck_d;
            busy_q    <= busy_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Directed bench for xvc_jtag_shifter; a TCK-clocked target model echoes TDI one bit late.
module tb_xvc_jtag_shifter;
    import xvc_pkg::*;

    localparam int D  = 5;
    localparam int AW = 5;

    logic clk100 = 1'b0;
    logic resetn;
    logic jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, busy;
    logic model_clr, model_q;
    int   checks = 0;
    int   errors = 0;

    xvc_jtag_shifter_if #(.ADDR_W(AW)) axil ();

    xvc_jtag_shifter #(.TCK_DIV(D), .ADDR_W(AW)) dut (
        .clk100   (clk100),
        .resetn   (resetn),
        .axil     (axil),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo),
        .busy     (busy)
    );

    always #5 clk100 = ~clk100;

    // Target model: TDO presents the TDI bit seen at the previous rising TCK.
    always @(posedge jtag_tck or posedge model_clr) begin
        if (model_clr) model_q <= 1'b0;
        else           model_q <= jtag_tdi;
    end
    assign jtag_tdo = model_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_tdo(input logic [31:0] tdi, input int n);
        logic [31:0] m;
        m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
`ifdef XVC_LOOPBACK_EN
        return tdi & m;
`else
        return (tdi << 1) & m;
`endif
    endfunction

    task automatic axi_write(input int unsigned addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk100);
        axil.s_axil_awaddr  = AW'(addr);
        axil.s_axil_wdata   = data;
        axil.s_axil_wstrb   = strb;
        axil.s_axil_awvalid = 1'b1;
        axil.s_axil_wvalid  = 1'b1;
        axil.s_axil_bready  = 1'b1;
        n = 0;
        do begin @(negedge clk100); n++; end while (!axil.s_axil_awready && n < 20);
        check_eq("aw_handshake", {31'd0, axil.s_axil_awready}, 32'd1);
        @(posedge clk100); #1;
        axil.s_axil_awvalid = 1'b0;
        axil.s_axil_wvalid  = 1'b0;
        @(negedge clk100);
        check_eq("bvalid", {31'd0, axil.s_axil_bvalid}, 32'd1);
    endtask

    task automatic axi_read(input int unsigned addr, output logic [31:0] data);
        int n;
        @(negedge clk100);
        axil.s_axil_araddr  = AW'(addr);
        axil.s_axil_arvalid = 1'b1;
        axil.s_axil_rready  = 1'b1;
        n = 0;
        do begin @(negedge clk100); n++; end while (!axil.s_axil_arready && n < 20);
        check_eq("ar_handshake", {31'd0, axil.s_axil_arready}, 32'd1);
        @(posedge clk100); #1;
        axil.s_axil_arvalid = 1'b0;
        @(negedge clk100);
        check_eq("rvalid", {31'd0, axil.s_axil_rvalid}, 32'd1);
        data = axil.s_axil_rdata;
        @(posedge clk100); #1;
    endtask

    task automatic wait_idle(output int cyc, output int pulses);
        logic prev;
        cyc = 0; pulses = 0; prev = jtag_tck;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            cyc++;
            @(negedge clk100);
            if (jtag_tck && !prev) pulses++;
            prev = jtag_tck;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic start_shift(input logic [31:0] len, input logic [31:0] tms, input logic [31:0] tdi);
        axi_write(OFF_LEN, len, 4'hF);
        axi_write(OFF_TMS, tms, 4'hF);
        axi_write(OFF_TDI, tdi, 4'hF);
        model_clr = 1'b1; #1; model_clr = 1'b0;
        axi_write(OFF_CTRL, 32'd1, 4'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int cyc, pulses;
        resetn = 1'b0;
        model_clr = 1'b1;
        axil.s_axil_awaddr = '0; axil.s_axil_awvalid = 1'b0; axil.s_axil_wdata = 32'd0;
        axil.s_axil_wstrb = 4'h0; axil.s_axil_wvalid = 1'b0; axil.s_axil_bready = 1'b0;
        axil.s_axil_araddr = '0; axil.s_axil_arvalid = 1'b0; axil.s_axil_rready = 1'b0;
        repeat (3) @(negedge clk100);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_tck",   {31'd0, jtag_tck}, 32'd0);
        check_eq("rst_tms",   {31'd0, jtag_tms}, 32'd0);
        check_eq("rst_tdi",   {31'd0, jtag_tdi}, 32'd0);
        check_eq("rst_ready", {29'd0, axil.s_axil_awready, axil.s_axil_wready, axil.s_axil_arready}, 32'd0);
        check_eq("rst_valid", {30'd0, axil.s_axil_bvalid, axil.s_axil_rvalid}, 32'd0);
        check_eq("rst_rdata", axil.s_axil_rdata, 32'd0);
        resetn = 1'b1;
        model_clr = 1'b0;
        axi_read(OFF_TDO, rd);
        check_eq("rst_tdo_reg", rd, 32'd0);

        // 8 bits of 0xA5
        start_shift(32'd8, 32'h0, 32'hA5);
        wait_idle(cyc, pulses);
        check_eq("len8_busy_cycles", 32'(cyc), 32'(2 * D * 8 + 1));
        check_eq("len8_pulses", 32'(pulses), 32'd8);
        axi_read(OFF_TDO, rd);
        check_eq("len8_tdo", rd, exp_tdo(32'hA5, 8));
        axi_read(OFF_CTRL, rd);
        check_eq("ctrl_idle", rd, 32'd0);

        // Partial strobe write is dropped; unmapped read returns 0
        axi_write(OFF_LEN, 32'd3, 4'h3);
        axi_read(OFF_LEN, rd);
        check_eq("strb_partial", rd, 32'd8);
        axi_read(32'h14, rd);
        check_eq("unmapped_rd", rd, 32'd0);

        // 32 bits of 0xDEADBEEF, TMS all ones; bit 0 presented on first busy cycle
        start_shift(32'd32, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        check_eq("first_busy", {31'd0, busy}, 32'd1);
        check_eq("first_tms", {31'd0, jtag_tms}, 32'd1);
        check_eq("first_tdi", {31'd0, jtag_tdi}, 32'd1);
        check_eq("first_tck", {31'd0, jtag_tck}, 32'd0);
        wait_idle(cyc, pulses);
        check_eq("len32_pulses", 32'(pulses), 32'd32);
        axi_read(OFF_TDO, rd);
        check_eq("len32_tdo", rd, exp_tdo(32'hDEAD_BEEF, 32));

        // LEN above 32 clamps
        start_shift(32'd40, 32'h0, 32'h0F0F_00FF);
        wait_idle(cyc, pulses);
        check_eq("len40_pulses", 32'(pulses), 32'd32);
        check_eq("len40_busy_cycles", 32'(cyc), 32'(2 * D * 32 + 1));
        axi_read(OFF_TDO, rd);
        check_eq("len40_tdo", rd, exp_tdo(32'h0F0F_00FF, 32));

        // TDI write during a shift is ignored
        start_shift(32'd8, 32'h0, 32'h3C);
        axi_write(OFF_TDI, 32'h1234, 4'hF);
        axi_read(OFF_TDI, rd);
        check_eq("busy_tdi_readback", rd, 32'h3C);
        axi_read(OFF_CTRL, rd);
        check_eq("ctrl_busy", rd, 32'd1);
        axi_read(OFF_TDO, rd);
        check_eq("busy_tdo_prev", rd, exp_tdo(32'h0F0F_00FF, 32));
        wait_idle(cyc, pulses);
        axi_read(OFF_TDO, rd);
        check_eq("busy_tdo_result", rd, exp_tdo(32'h3C, 8));

        // RVALID/RDATA held while RREADY low
        @(negedge clk100);
        axil.s_axil_araddr = AW'(OFF_LEN);
        axil.s_axil_arvalid = 1'b1;
        axil.s_axil_rready = 1'b0;
        for (int i = 0; i < 20 && !axil.s_axil_arready; i++) @(negedge clk100);
        @(posedge clk100); #1;
        axil.s_axil_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk100);
            check_eq("hold_rvalid", {31'd0, axil.s_axil_rvalid}, 32'd1);
            check_eq("hold_rdata", axil.s_axil_rdata, 32'd8);
        end
        axil.s_axil_rready = 1'b1;
        @(posedge clk100); #1;
        check_eq("hold_release", {31'd0, axil.s_axil_rvalid}, 32'd0);

        // Zero length: one DONE cycle, no TCK
        start_shift(32'd0, 32'h0, 32'hFFFF_FFFF);
        wait_idle(cyc, pulses);
        check_eq("len0_busy_cycles", 32'(cyc), 32'd1);
        check_eq("len0_pulses", 32'(pulses), 32'd0);
        axi_read(OFF_TDO, rd);
        check_eq("len0_tdo", rd, 32'd0);

        // Reset during the HIGH phase of bit 3 of a 16-bit shift
        start_shift(32'd16, 32'h0, 32'h0000_FFFF);
        repeat (6 * D + D) @(negedge clk100);
        check_eq("pre_rst_tck", {31'd0, jtag_tck}, 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_tck", {31'd0, jtag_tck}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk100);
        resetn = 1'b1;
        axi_read(OFF_TDO, rd);
        check_eq("rst_mid_tdo", rd, 32'd0);
        start_shift(32'd4, 32'h0, 32'h9);
        wait_idle(cyc, pulses);
        check_eq("post_rst_pulses", 32'(pulses), 32'd4);
        axi_read(OFF_TDO, rd);
        check_eq("post_rst_tdo", rd, exp_tdo(32'h9, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
